vga_frame_buff_dbl: RTL and testbench

Double-buffered VGA frame buffer with an AXI4-Lite subordinate.
- The VGA scan-out reads the front buffer on pxclk.
- Software writes and reads the back buffer over AXI on axi.aclk.
- A software-requested page flip takes effect only at the next frame start, so there is no tearing.
- Sits between the VGA timing generator and the system interconnect. Each buffer is a byte-lane-enabled dual-port RAM (dual_port_ram).

---
 rtl/vga_frame_buff_dbl_if.sv | 43 ++++
 rtl/vga_frame_buff_dbl.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_vga_frame_buff_dbl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_buff_dbl_if.sv
// rtl/vga_frame_buff_dbl_if.sv - AXI4-Lite bus interface used by the double-buffered VGA frame buffer
interface axi4_lite #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32
) (
  input logic aclk
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    input  aclk,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport subordinate (
    input  aclk,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  aclk,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/vga_frame_buff_dbl.sv
// rtl/vga_frame_buff_dbl.sv - double-buffered VGA frame buffer with AXI4-Lite back-buffer access
// Optional macro VGA_FB_FLIP_IRQ_EN adds the FLIP_DONE/IRQ_EN bits and the irq output.
module dual_port_ram #(
  parameter int WORDS = 16,
  parameter int AW    = 4
) (
  input  logic          a_clk,
  input  logic          a_rst_n,
  input  logic [AW-1:0] a_addr,
  output logic [31:0]   a_dout,
  input  logic          b_clk,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [3:0]    b_be,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_din,
  output logic [31:0]   b_dout
);
  logic [31:0] mem [WORDS];

  always_ff @(posedge a_clk) begin
    if (!a_rst_n) a_dout <= '0;
    else          a_dout <= mem[a_addr];
  end

  // b_dout only moves on a read, so it stays put while a response is pending
  always_ff @(posedge b_clk) begin
    if (b_en) begin
      if (b_we) begin
        for (int i = 0; i < 4; i++)
          if (b_be[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
      end else begin
        b_dout <= mem[b_addr];
      end
    end
  end
endmodule

module vga_frame_buff_dbl #(
  parameter int PIXEL_WIDTH    = 640,
  parameter int PIXEL_HEIGHT   = 480,
  parameter int PIXEL_DEPTH    = 8,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                                       pxclk,
  input  logic                                       rst_n,
  input  logic                                       frame_start,
  input  logic [$clog2(PIXEL_WIDTH*PIXEL_HEIGHT)-1:0] px_addr,
  output logic [PIXEL_DEPTH-1:0]                     px_data,
  output logic                                       disp_buf,
`ifdef VGA_FB_FLIP_IRQ_EN
  output logic                                       irq,
`endif
  axi4_lite.subordinate                              axi
);
  localparam int FB_BYTES       = PIXEL_WIDTH*PIXEL_HEIGHT*PIXEL_DEPTH/8;
  localparam int AXI_ADDR_WIDTH = $clog2(FB_BYTES) + 1;
  localparam int OW             = AXI_ADDR_WIDTH - 1;
  localparam int FB_WORDS       = FB_BYTES / 4;
  localparam int WA             = $clog2(FB_WORDS);
  localparam int WORD_PIX       = 32 / PIXEL_DEPTH;
  localparam int LANE_BITS      = $clog2(WORD_PIX);
  localparam logic [1:0] LANE_MASK = 2'(WORD_PIX - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] FB_LIMIT = AXI_ADDR_WIDTH'(FB_BYTES);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

  if (PIXEL_DEPTH != 8 && PIXEL_DEPTH != 16 && PIXEL_DEPTH != 32) begin : g_bad_depth
    $error("PIXEL_DEPTH must be 8, 16 or 32");
  end
  if (AXI_DATA_WIDTH != 32) begin : g_bad_width
    $error("AXI_DATA_WIDTH must be 32");
  end

  typedef enum logic [1:0] {REG_ERR, REG_FB, REG_CTRL, REG_CNT} region_e;
  typedef enum logic [1:0] {AW_IDLE, W_WAIT, WR_RAM, B_VALID} wr_state_e;
  typedef enum logic [1:0] {AR_IDLE, RD_RAM, R_VALID} rd_state_e;

  function automatic region_e region(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [OW-1:0] off;
    off = a[OW-1:0];
    if (!a[OW]) return (off[1:0] == 2'b00 && {1'b0, off} < FB_LIMIT) ? REG_FB : REG_ERR;
    if (off == '0)     return REG_CTRL;
    if (off == OW'(4)) return REG_CNT;
    return REG_ERR;
  endfunction

  function automatic logic [15:0] gray2bin(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // ---------------- pxclk domain ----------------
  logic [15:0] frame_cnt, frame_gray, cnt_nxt;
  logic [1:0]  req_sync, lane_q;
  logic        ack_tgl, px_sel_q, req_tgl;
  logic [31:0] a_dout0, a_dout1, px_word, px_shift;
  logic [WA-1:0] px_word_addr;

  assign cnt_nxt      = frame_cnt + 16'd1;
  assign px_word_addr = WA'(px_addr >> LANE_BITS);

  // A flip is taken on the frame_start edge that sees the request, never mid-frame
  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      disp_buf   <= 1'b0;
      ack_tgl    <= 1'b0;
      req_sync   <= '0;
      frame_cnt  <= '0;
      frame_gray <= '0;
      px_sel_q   <= 1'b0;
      lane_q     <= '0;
    end else begin
      req_sync <= {req_sync[0], req_tgl};
      px_sel_q <= disp_buf;
      lane_q   <= 2'(px_addr) & LANE_MASK;
      if (frame_start) begin
        frame_cnt  <= cnt_nxt;
        frame_gray <= cnt_nxt ^ (cnt_nxt >> 1);
        if (req_sync[1] != ack_tgl) begin
          disp_buf <= ~disp_buf;
          ack_tgl  <= ~ack_tgl;
        end
      end
    end
  end

  assign px_word  = px_sel_q ? a_dout1 : a_dout0;
  assign px_shift = px_word >> (6'(lane_q) * 6'(PIXEL_DEPTH));
  assign px_data  = px_shift[PIXEL_DEPTH-1:0];

  // ---------------- aclk domain ----------------
  wr_state_e wr_state;
  rd_state_e rd_state;
  logic [AXI_ADDR_WIDTH-1:0] waddr_q, raddr_q;
  logic [31:0] wdata_q, rdata_q, b_dout0, b_dout1, ctrl_val;
  logic [3:0]  wstrb_q;
  logic [1:0]  ack_sync, disp_sync;
  logic [15:0] gray_s0, gray_s1;
  logic        w_have, flip_req, axi_buf, ack_seen;
  logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q, rd_src_ram, rd_buf_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        wr_ram_req, rd_en, we0, we1;
  logic [WA-1:0] b_addr;
  region_e     wr_kind, rd_kind;
`ifdef VGA_FB_FLIP_IRQ_EN
  logic        flip_done, irq_en;
  assign irq      = flip_done & irq_en;
  assign ctrl_val = {27'b0, irq_en, flip_done, disp_sync[1], axi_buf, flip_req};
`else
  assign ctrl_val = {29'b0, disp_sync[1], axi_buf, flip_req};
`endif

  assign wr_kind    = region(waddr_q);
  assign rd_kind    = region(raddr_q);
  // Writes own port B whenever both FSMs want it; the read retries next cycle
  assign wr_ram_req = (wr_state == WR_RAM) && (wr_kind == REG_FB);
  assign rd_en      = (rd_state == RD_RAM) && (rd_kind == REG_FB) && !wr_ram_req;
  assign we0        = wr_ram_req && !axi_buf;
  assign we1        = wr_ram_req && axi_buf;
  assign b_addr     = wr_ram_req ? waddr_q[WA+1:2] : raddr_q[WA+1:2];

  always_ff @(posedge axi.aclk) begin
    if (!rst_n) begin
      disp_sync <= '0;
      gray_s0   <= '0;
      gray_s1   <= '0;
    end else begin
      disp_sync <= {disp_sync[0], disp_buf};
      gray_s0   <= frame_gray;
      gray_s1   <= gray_s0;
    end
  end

  always_ff @(posedge axi.aclk) begin
    if (!rst_n) begin
      wr_state  <= AW_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      w_have    <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      flip_req  <= 1'b0;
      req_tgl   <= 1'b0;
      axi_buf   <= 1'b1;
      ack_sync  <= '0;
      ack_seen  <= 1'b0;
`ifdef VGA_FB_FLIP_IRQ_EN
      flip_done <= 1'b0;
      irq_en    <= 1'b0;
`endif
    end else begin
      ack_sync <= {ack_sync[0], ack_tgl};
      case (wr_state)
        AW_IDLE: begin
          if (axi.awvalid && awready_q) begin
            waddr_q   <= axi.awaddr;
            awready_q <= 1'b0;
            if (w_have || (axi.wvalid && wready_q)) begin
              if (!w_have) begin
                wdata_q <= axi.wdata;
                wstrb_q <= axi.wstrb;
              end
              w_have   <= 1'b0;
              wready_q <= 1'b0;
              wr_state <= WR_RAM;
            end else begin
              wready_q <= 1'b1;
              wr_state <= W_WAIT;
            end
          end else if (axi.wvalid && wready_q) begin
            wdata_q  <= axi.wdata;
            wstrb_q  <= axi.wstrb;
            w_have   <= 1'b1;
            wready_q <= 1'b0;
          end else begin
            wready_q <= !w_have;
          end
        end
        W_WAIT: begin
          if (axi.wvalid && wready_q) begin
            wdata_q  <= axi.wdata;
            wstrb_q  <= axi.wstrb;
            wready_q <= 1'b0;
            wr_state <= WR_RAM;
          end
        end
        WR_RAM: begin
          bvalid_q <= 1'b1;
          wr_state <= B_VALID;
          bresp_q  <= (wr_kind == REG_ERR) ? RESP_SLVERR : RESP_OKAY;
          if (wr_kind == REG_CTRL && wstrb_q[0]) begin
            if (wdata_q[0] && !flip_req) begin
              flip_req <= 1'b1;
              req_tgl  <= ~req_tgl;
            end
`ifdef VGA_FB_FLIP_IRQ_EN
            if (wdata_q[3]) flip_done <= 1'b0;
            irq_en <= wdata_q[4];
`endif
          end
        end
        default: begin
          if (axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wr_state  <= AW_IDLE;
          end
        end
      endcase
      if (ack_sync[1] != ack_seen) begin
        ack_seen <= ack_sync[1];
        axi_buf  <= ~axi_buf;
        flip_req <= 1'b0;
`ifdef VGA_FB_FLIP_IRQ_EN
        flip_done <= 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge axi.aclk) begin
    if (!rst_n) begin
      rd_state   <= AR_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      raddr_q    <= '0;
      rd_src_ram <= 1'b0;
      rd_buf_q   <= 1'b0;
    end else begin
      case (rd_state)
        AR_IDLE: begin
          if (axi.arvalid && arready_q) begin
            raddr_q   <= axi.araddr;
            arready_q <= 1'b0;
            rd_state  <= RD_RAM;
          end
        end
        RD_RAM: begin
          if (rd_kind != REG_FB || !wr_ram_req) begin
            rd_src_ram <= (rd_kind == REG_FB);
            rd_buf_q   <= axi_buf;
            rresp_q    <= (rd_kind == REG_ERR) ? RESP_SLVERR : RESP_OKAY;
            rdata_q    <= (rd_kind == REG_CTRL) ? ctrl_val :
                          (rd_kind == REG_CNT)  ? {16'b0, gray2bin(gray_s1)} : 32'b0;
            rvalid_q   <= 1'b1;
            rd_state   <= R_VALID;
          end
        end
        default: begin
          if (axi.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rd_state  <= AR_IDLE;
          end
        end
      endcase
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rresp   = rresp_q;
  assign axi.rdata   = rd_src_ram ? (rd_buf_q ? b_dout1 : b_dout0) : rdata_q;

  dual_port_ram #(.WORDS(FB_WORDS), .AW(WA)) u_buf0 (
    .a_clk(pxclk), .a_rst_n(rst_n), .a_addr(px_word_addr), .a_dout(a_dout0),
    .b_clk(axi.aclk), .b_en(rd_en || we0), .b_we(we0), .b_be(wstrb_q),
    .b_addr(b_addr), .b_din(wdata_q), .b_dout(b_dout0)
  );

  dual_port_ram #(.WORDS(FB_WORDS), .AW(WA)) u_buf1 (
    .a_clk(pxclk), .a_rst_n(rst_n), .a_addr(px_word_addr), .a_dout(a_dout1),
    .b_clk(axi.aclk), .b_en(rd_en || we1), .b_we(we1), .b_be(wstrb_q),
    .b_addr(b_addr), .b_din(wdata_q), .b_dout(b_dout1)
  );
endmodule

// File: tb/tb_vga_frame_buff_dbl.sv
// tb/tb_vga_frame_buff_dbl.sv - directed-vector bench for vga_frame_buff_dbl (10x4 pixels, 8 bpp)
module tb_vga_frame_buff_dbl;
  localparam int PW = 10, PH = 4, PD = 8, AW = 7;
  localparam logic [6:0] REG_CTRL = 7'h40, REG_CNT = 7'h44;

  logic       pxclk = 1'b0, aclk = 1'b0, rst_n = 1'b0, frame_start = 1'b0;
  logic [5:0] px_addr = '0;
  logic [7:0] px_data;
  logic       disp_buf;
`ifdef VGA_FB_FLIP_IRQ_EN
  logic       irq;
`endif

  always #4 pxclk = ~pxclk;
  always #5 aclk  = ~aclk;

  axi4_lite #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) axi (.aclk(aclk));

  vga_frame_buff_dbl #(.PIXEL_WIDTH(PW), .PIXEL_HEIGHT(PH), .PIXEL_DEPTH(PD), .AXI_DATA_WIDTH(32)) dut (
    .pxclk(pxclk), .rst_n(rst_n), .frame_start(frame_start), .px_addr(px_addr),
    .px_data(px_data), .disp_buf(disp_buf),
`ifdef VGA_FB_FLIP_IRQ_EN
    .irq(irq),
`endif
    .axi(axi)
  );

  int  vectors = 0, miscompares = 0;
  time t_b, t_r;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit awd = 0, wd = 0, hs_aw, hs_w;
    int n = 0;
    @(negedge aclk);
    axi.awaddr = a; axi.awvalid = 1'b1;
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
    axi.bready = 1'b1;
    while (!(awd && wd) && n < 50) begin
      hs_aw = axi.awvalid && axi.awready;
      hs_w  = axi.wvalid && axi.wready;
      @(posedge aclk); #1;
      if (hs_aw) begin axi.awvalid = 1'b0; awd = 1; end
      if (hs_w)  begin axi.wvalid  = 1'b0; wd  = 1; end
      @(negedge aclk);
      n++;
    end
    check("aw_w_accept", {30'b0, awd, wd}, 32'h3);
    while (!axi.bvalid && n < 50) begin @(negedge aclk); n++; end
    check("bvalid", axi.bvalid, 1);
    resp = axi.bresp;
    t_b = $time;
    @(posedge aclk); #1;
    axi.bready = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
    bit ard = 0, hs;
    int n = 0;
    @(negedge aclk);
    axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b1;
    while (!ard && n < 50) begin
      hs = axi.arready;
      @(posedge aclk); #1;
      if (hs) begin axi.arvalid = 1'b0; ard = 1; end
      @(negedge aclk);
      n++;
    end
    while (!axi.rvalid && n < 50) begin @(negedge aclk); n++; end
    check("rvalid", axi.rvalid, 1);
    lat = n;
    d = axi.rdata; resp = axi.rresp;
    t_r = $time;
    @(posedge aclk); #1;
    axi.rready = 1'b0; axi.arvalid = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge pxclk); frame_start = 1'b1;
    @(negedge pxclk); frame_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  rr, br;
    int          lat;
    logic [7:0]  px_exp [4];
    px_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0;
    axi.bready = 0; axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;

    // reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_disp_buf", disp_buf, 0);
    check("rst_px_data", px_data, 0);
    check("rst_arready", axi.arready, 1);
    check("rst_awready", axi.awready, 1);
    check("rst_wready", axi.wready, 0);
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_bvalid", axi.bvalid, 0);
    check("rst_rresp", axi.rresp, 0);
    check("rst_bresp", axi.bresp, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge aclk);

    axi_read(REG_CTRL, d, rr, lat);
    check("ctrl_after_reset", d, 32'h2);
    check("ctrl_rresp", rr, 0);

    // full word then byte-lane write to back buffer
    axi_write(7'h10, 32'hA5A5A5A5, 4'hF, br);
    check("wr10_bresp", br, 0);
    axi_read(7'h10, d, rr, lat);
    check("rd10_full", d, 32'hA5A5A5A5);
    axi_write(7'h10, 32'h0000003C, 4'h1, br);
    axi_read(7'h10, d, rr, lat);
    check("rd10_byte", d, 32'hA5A5A53C);

    // flip and scan out the new front buffer
    axi_write(7'h00, 32'h44332211, 4'hF, br);
    axi_write(REG_CTRL, 32'h1, 4'hF, br);
    repeat (6) @(posedge pxclk);
    pulse_frame();
    @(negedge pxclk);
    check("flip1_disp_buf", disp_buf, 1);
    for (int i = 0; i <= 4; i++) begin
      @(negedge pxclk);
      if (i > 0) check($sformatf("px_data%0d", i - 1), px_data, px_exp[i-1]);
      if (i < 4) px_addr = 6'(i);
    end
    repeat (10) @(posedge aclk);
    axi_read(REG_CTRL, d, rr, lat);
    check("ctrl_after_flip", d, 32'h4);

    // pending flip waits for frame_start; repeated request gives one flip
    axi_write(REG_CTRL, 32'h1, 4'hF, br);
    repeat (1000) @(posedge pxclk);
    @(negedge pxclk);
    check("no_frame_disp_buf", disp_buf, 1);
    axi_read(REG_CTRL, d, rr, lat);
    check("flip_req_pending", d, 32'h5);
    axi_write(REG_CTRL, 32'h1, 4'hF, br);
    pulse_frame();
    repeat (4) @(posedge pxclk);
    @(negedge pxclk);
    check("flip2_disp_buf", disp_buf, 0);
    repeat (10) @(posedge aclk);
    pulse_frame();
    repeat (10) @(posedge aclk);
    @(negedge pxclk);
    check("one_flip_only", disp_buf, 0);
    axi_read(REG_CTRL, d, rr, lat);
    check("ctrl_after_flip2", d, 32'h2);
    axi_read(REG_CNT, d, rr, lat);
    check("frame_cnt", d, 32'h3);

    // error responses and boundaries
    axi_write(7'h04, 32'h12345678, 4'hF, br);
    axi_read(7'h02, d, rr, lat);
    check("rd_unaligned_resp", rr, 2'b10);
    check("rd_unaligned_data", d, 0);
    axi_write(7'h06, 32'hFFFFFFFF, 4'hF, br);
    check("wr_unaligned_resp", br, 2'b10);
    axi_read(7'h48, d, rr, lat);
    check("rd_badreg_resp", rr, 2'b10);
    check("rd_badreg_data", d, 0);
    axi_read(7'h28, d, rr, lat);
    check("rd_oob_resp", rr, 2'b10);
    axi_write(7'h28, 32'hFFFFFFFF, 4'hF, br);
    check("wr_oob_resp", br, 2'b10);
    axi_read(7'h04, d, rr, lat);
    check("rd04_unchanged", d, 32'h12345678);
    axi_write(7'h24, 32'hCAFEF00D, 4'hF, br);
    check("wr_last_resp", br, 0);
    axi_read(7'h24, d, rr, lat);
    check("rd_last_word", d, 32'hCAFEF00D);

    // simultaneous read and write to one address
    fork
      axi_write(7'h08, 32'hDEADBEEF, 4'hF, br);
      axi_read(7'h08, d, rr, lat);
    join
    check("conc_rdata", d, 32'hDEADBEEF);
    check("conc_rresp", rr, 0);
    check("conc_lat_le4", (lat <= 4), 1);
    check("conc_write_first", (t_b < t_r), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
